uart_rx_fifo_param: RTL
=======================

Name: uart_rx_fifo_param

Overview:
Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Configurable bit period, data width, parity and stop-bit count.
- Samples at mid-bit behind a 2-flop synchroniser and rejects false start bits.
- Reports framing and parity errors per word.
- Buffers received words in a small FIFO with overrun detection.
- Sits between the board RX pin and the CPU/IO bus, which drains words via rd_en.

Parameters:
CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 8..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, FIFO entries; power of two, 2..64.

Ports:
clock_50M  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop FIFO head; ignored when empty
err_clr  in  1  clears sticky overrun
rx_data  out  DATA_BITS  FIFO head data, first-word fall-through
rx_fe  out  1  framing error flag of head word
rx_pe  out  1  parity error flag of head word; always 0 when PARITY=0
empty  out  1  FIFO empty
full  out  1  FIFO full
busy  out  1  frame in progress (state != IDLE)
overrun  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- One clock: clock_50M. Reset: n_rst is synchronous and active-low. All state updates on the rising edge.
- Reset values: rx_data=0, rx_fe=0, rx_pe=0, empty=1, full=0, busy=0, overrun=0. FIFO pointers and count = 0. Synchroniser flops = 1. FSM = IDLE.
- Synchroniser: rx -> s1 -> s2 (rx_s). The FSM uses rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - armed only after rx_s has been sampled high at least once since reset or since the last frame ended.
  - armed and rx_s low -> START; bit counter cleared; cycle counter loaded with CLK_DIV/2 - 1 (integer division).
- START: counter reaches 0 -> sample rx_s.
  - high = glitch -> IDLE; nothing pushed.
  - low -> DATA; counter reloaded with CLK_DIV-1.
- DATA: one sample each time the counter reaches 0, LSB first, shifted into the data register. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY:
  - pe = (XOR of data bits XOR parity bit) != (PARITY==1 ? 1 : 0); i.e. odd parity expects total XOR 1, even expects 0.
- STOP: STOP_BITS samples. fe=1 if any stop sample is low.
  - After the last stop sample, the word {fe, pe, data} is pushed in the next cycle and the FSM enters IDLE.
  - If fe=1 and rx_s is still low (break), IDLE stays unarmed until rx_s goes high.
- Timing: first sample is CLK_DIV/2 cycles after the cycle rx_s first reads low. Every later sample is CLK_DIV cycles after the previous one. Back-to-back frames are received with no lost bits.
- busy=1 in every state except IDLE.
- FIFO:
  - Push when the FIFO is not full, or when it is full and rd_en=1 in the same cycle.
  - Otherwise the word is dropped and overrun is set.
  - Outputs show the head entry whenever empty=0; rx_data/rx_fe/rx_pe are don't-care when empty.
  - Push and pop in the same cycle: count unchanged, both succeed.
  - Pointers wrap modulo FIFO_DEPTH.
- overrun: cleared by err_clr. If a set and err_clr coincide, set wins.
- Reset mid-frame: the frame is discarded, the FIFO is flushed, and the next clean frame is received normally.

Decomposition:
- Shared header uart_defs.vh holds:
  - parity encodings: PARITY_NONE/ODD/EVEN = 0/1/2
  - FSM state encodings
  - default 50 MHz/115200 CLK_DIV constant, shared with the TX side
- Sub-module uart_fifo (parametrised width and depth, synchronous active-low reset, FWFT). It is reusable by the future TX FIFO.
- The top level contains the synchroniser, FSM, counters and shift register.

Test Plan:
All scenarios use CLK_DIV=16.
1. 8N1, send 0xA5 -> empty falls one cycle after the stop sample; rx_data=0xA5, rx_fe=0, rx_pe=0; rd_en pulse -> empty=1.
2. rx low for 5 cycles then high (shorter than CLK_DIV/2) -> no push, empty stays 1, busy returns to 0 after the start sample.
3. PARITY=2, DATA_BITS=7: send 0x03 with parity bit 0 -> rx_data=0x03, rx_pe=0. Repeat with parity bit 1 -> rx_pe=1.
4. Stop bit driven low, line held low for 40 cycles then high -> word pushed with rx_fe=1; no second frame starts until the line goes high; a following 0x3C is received clean.
5. FIFO_DEPTH=4: send 0x11..0x15 with no reads -> full=1, overrun=1. Reads return 0x11, 0x12, 0x13, 0x14, then empty. err_clr -> overrun=0.
6. Assert n_rst low mid-DATA of 0x5A for 1 cycle -> all outputs at reset values. Next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_param_pkg.sv
// Shared UART encodings: parity modes, receiver FSM states and the default bit period.
package uart_rx_fifo_param_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 50 MHz / 115200 baud, also used by the TX side
  localparam int CLK_DIV_50M_115200 = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_param_fifo.sv
// First-word fall-through FIFO, synchronous active-low reset; shared by the RX and TX paths.
module uart_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a word when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM, per-word error flags, FIFO.
module uart_rx_fifo_param
  import uart_rx_fifo_param_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_50M_115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock_50M,
  input  logic                 n_rst,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_fe,
  output logic                 rx_pe,
  output logic                 empty,
  output logic                 full,
  output logic                 busy,
  output logic                 overrun
);
  localparam int W = DATA_BITS + 2;

  rx_state_e            state_q, state_d;
  logic                 s1_q, s2_q, rx_s;
  logic                 armed_q, armed_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 pe_q, pe_d, fe_q, fe_d;
  logic                 overrun_q, overrun_d;
  logic                 push, tick;
  logic [W-1:0]         push_word, head_word;

  assign rx_s = s2_q;
  assign tick = (cnt_q == '0);
  assign busy = (state_q != ST_IDLE);
  assign push_word = {fe_q | ~rx_s, pe_q, data_q};

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    cnt_d     = tick ? 16'(CLK_DIV - 1) : cnt_q - 16'd1;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d   = ST_START;
          cnt_d     = 16'(CLK_DIV / 2 - 1);
          bit_cnt_d = '0;
          pe_d      = 1'b0;
          fe_d      = 1'b0;
        end
      end
      ST_START: if (tick) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA: if (tick) begin
        data_d    = {rx_s, data_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
          bit_cnt_d = '0;
          state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (tick) begin
        pe_d    = ((^data_q) ^ rx_s) != (PARITY == PARITY_ODD);
        state_d = ST_STOP;
      end
      ST_STOP: if (tick) begin
        if (!rx_s) fe_d = 1'b1;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
          // Re-arm only once the line is seen high, so a break cannot retrigger
          push    = 1'b1;
          armed_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (err_clr) overrun_d = 1'b0;
    if (push && full && !rd_en) overrun_d = 1'b1;
  end

  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= rx;
      s2_q      <= s1_q;
      state_q   <= state_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock_50M),
    .rst_ni  (n_rst),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (rd_en),
    .rdata_o (head_word),
    .empty_o (empty),
    .full_o  (full)
  );

  assign rx_fe   = head_word[W-1];
  assign rx_pe   = head_word[W-2];
  assign rx_data = head_word[DATA_BITS-1:0];
  assign overrun = overrun_q;

endmodule
